// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path and its line conditioning.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // data bits, odd parity and stop bit; the start bit is produced by the FSM itself
    localparam int FRAME_BITS = 10;

    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] byte_in);
        return {1'b1, ~^byte_in, byte_in};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for the PS/2 clock and data pins,
// with a one-cycle pulse on each accepted falling edge of the clock line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_filt,
    output logic data_filt,
    output logic data_sync,
    output logic clk_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // index 0 is the clock line, index 1 the data line
    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [1:0]    filt_q;
    logic [1:0]    filt_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          fall_q;
    logic          fall_d;

    always_comb begin
        filt_d   = filt_q;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        fall_d = filt_q[0] & ~filt_d[0];
    end

    // lines reset to the idle-high level so leaving reset never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            filt_q   <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            fall_q   <= 1'b0;
        end else begin
            meta_q   <= {data_raw, clk_raw};
            sync_q   <= meta_q;
            filt_q   <= filt_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            fall_q   <= fall_d;
        end
    end

    assign clk_filt  = filt_q[0];
    assign data_filt = filt_q[1];
    assign data_sync = sync_q[1];
    assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain enables for the
// clock and data pins; the pad-level tristate lives in the parent.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_SAT  = TW'(TMR_MAX);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    logic clk_filt;
    logic data_filt;
    logic data_sync;
    logic clk_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .clk_raw   (ps2_clk_in),
        .data_raw  (ps2_data_in),
        .clk_filt  (clk_filt),
        .data_filt (data_filt),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    ps2_state_e            state_q,   state_d;
    logic [FRAME_BITS-1:0] shift_q,   shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         tmr_q,     tmr_d;
    logic                  ready_q,   ready_d;
    logic                  clk_oe_q,  clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  done_q,    done_d;
    logic                  err_q,     err_d;

    logic [TW-1:0] tmr_inc;
    logic          timeout;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        ready_d   = ready_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        tmr_inc = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_ONE;
        timeout = (tmr_q >= TO_LAST);

        case (state_q)
            IDLE: begin
                ready_d   = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d   = ps2_frame(tx_data);
                    bit_cnt_d = 4'd0;
                    tmr_d     = '0;
                    clk_oe_d  = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr_q >= INH_LAST) begin
                    data_oe_d = 1'b1;
                    tmr_d     = '0;
                    state_d   = START;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            START: begin
                // start bit has been on the line for one cycle: hand the clock to the device
                if (clk_oe_q) begin
                    clk_oe_d = 1'b0;
                    tmr_d    = '0;
                end else if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = 4'd1;
                    tmr_d     = '0;
                    state_d   = DATA;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmr_d     = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    tmr_d = '0;
                    if (!data_filt) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a stalled device overrides whatever the edge logic decided this cycle
        if (timeout && (state_q inside {START, DATA, ACK, WAIT_IDLE})) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            ready_d   = 1'b1;
            tmr_d     = '0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            ready_q   <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            ready_q   <= ready_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = ~ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized checks of ps2_host_tx against a behavioural PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 100;
    localparam int TO  = 2000;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_glitch   = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | dev_glitch);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int   done_cnt    = 0;
    int   err_cnt     = 0;
    int   overlap_cnt = 0;
    int   wide_cnt    = 0;
    logic done_prev   = 1'b0;
    logic err_prev    = 1'b0;

    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
        if (tx_done && tx_err) overlap_cnt <= overlap_cnt + 1;
        if ((tx_done && done_prev) || (tx_err && err_prev)) wide_cnt <= wide_cnt + 1;
        done_prev <= tx_done;
        err_prev  <= tx_err;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected wire sequence seen by the device: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic host_start(input logic [7:0] b);
        int n;
        bit clk_drop;
        n = 0;
        while (!tx_ready && n < 5000) begin
            tick();
            n++;
        end
        check("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("inhibit_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("busy_after_capture", 32'(busy), 32'd1);
        n = 0;
        clk_drop = 1'b0;
        while (!ps2_data_oe && n < 500) begin
            tick();
            n++;
            if (!ps2_clk_oe) clk_drop = 1'b1;
        end
        check("inhibit_len", 32'(n), 32'(INH));
        check("inhibit_clk_held", 32'(clk_drop), 32'd0);
        check("start_clk_still_low", 32'(ps2_clk_oe), 32'd1);
        tick();
        check("clk_release", 32'(ps2_clk_oe), 32'd0);
        check("start_bit_driven", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device clocks nfalls edges (40-clk period), sampling the line just before each fall.
    task automatic dev_xfer(input int nfalls, input bit nack, input int glitch_k, output logic [10:0] smp);
        smp = '0;
        tick(10);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) begin
                smp[10] = ps2_data_in;
                tx_valid = 1'b0;
                dev_data_low = !nack;
                tick(10);
            end else begin
                smp[k-1] = ps2_data_in;
            end
            dev_clk_low = 1'b1;
            tick(20);
            dev_clk_low = 1'b0;
            if (k == glitch_k) begin
                tick(8);
                dev_glitch = 1'b1;
                tick(2);
                dev_glitch = 1'b0;
                tick(10);
            end else begin
                tick(20);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt - prev), 32'd1);
    endtask

    task automatic wait_err(input string tag, input int prev, input int bound);
        int n;
        n = 0;
        while (err_cnt == prev && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(err_cnt - prev), 32'd1);
    endtask

    task automatic xfer_ok(input logic [7:0] b, input int glitch_k, output logic [10:0] smp);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        host_start(b);
        dev_xfer(11, 1'b0, glitch_k, smp);
        check("frame", 32'(smp), 32'(ref_frame(b)));
        wait_done("done_once", d0);
        tick(2);
        check("no_err", 32'(err_cnt - e0), 32'd0);
        check("ready_after", 32'(tx_ready), 32'd1);
        check("oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        logic [10:0] smp;
        logic [7:0]  b;
        int          d0;
        int          e0;
        int          n;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        tick(5);

        xfer_ok(CMD_SET_LED, 0, smp);
        check("frame_ED_literal", 32'(smp), 32'(11'b1_1_11101101_0));
        xfer_ok(8'h00, 0, smp);
        check("parity_00", 32'(smp[9]), 32'd1);
        xfer_ok(8'h03, 0, smp);
        check("parity_03", 32'(smp[9]), 32'd1);
        xfer_ok(8'h07, 0, smp);
        check("parity_07", 32'(smp[9]), 32'd0);
        repeat (3) begin
            b = 8'($urandom_range(0, 255));
            xfer_ok(b, 0, smp);
        end

        // NACK at the acknowledge edge
        d0 = done_cnt;
        e0 = err_cnt;
        b  = 8'($urandom_range(0, 255));
        host_start(b);
        dev_xfer(11, 1'b1, 0, smp);
        wait_err("nack_err", e0, 500);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("nack_ready", 32'(tx_ready), 32'd1);

        // Device never clocks
        d0 = done_cnt;
        host_start(8'hA5);
        n = 0;
        while (!tx_err && n < 3000) begin
            tick();
            n++;
        end
        check("timeout_len", 32'(n), 32'(TO));
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_no_done", 32'(tx_done), 32'd0);
        tick(5);

        // Device stalls after bit 4, then a normal enable command
        e0 = err_cnt;
        b  = 8'($urandom_range(0, 255));
        host_start(b);
        dev_xfer(5, 1'b0, 0, smp);
        wait_err("stall_err", e0, 3000);
        check("stall_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        xfer_ok(CMD_ENABLE, 0, smp);

        // Asynchronous reset while bit 3 (a zero) is on the line
        d0 = done_cnt;
        e0 = err_cnt;
        host_start(8'h55);
        dev_xfer(4, 1'b0, 0, smp);
        check("bit3_driven", 32'(ps2_data_oe), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(60);
        check("post_rst_ready", 32'(tx_ready), 32'd1);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("post_rst_no_err", 32'(err_cnt - e0), 32'd0);

        // Request while busy must be dropped
        d0 = done_cnt;
        host_start(8'h3C);
        tx_data  = CMD_RESET;
        tx_valid = 1'b1;
        dev_xfer(11, 1'b0, 0, smp);
        check("busy_frame", 32'(smp), 32'(ref_frame(8'h3C)));
        wait_done("busy_done", d0);
        tick(300);
        check("busy_single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_no_requeue", 32'(ps2_clk_oe), 32'd0);
        check("busy_ready", 32'(tx_ready), 32'd1);

        // 2-clk glitch on the device clock during the data phase
        b = 8'($urandom_range(0, 255));
        xfer_ok(b, 4, smp);

        tick(5);
        check("pulse_overlap", 32'(overlap_cnt), 32'd0);
        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send direction that pairs with the keyboard receive decoder. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- The block does not touch the inout pins. It drives open-drain enables, and the top level ties each pin low when its enable is high and leaves it high-Z otherwise.
- While busy is high, the top masks the receive decoder's key_valid.

Parameters:
- INHIBIT_CYCLES, default 10000: clocks the host holds PS2_CLK low before the start bit (100 us at 100 MHz).
- TIMEOUT_CYCLES, default 1500000: maximum clocks allowed between device clock falling edges, or before the first edge, before the transfer aborts (15 ms).
- FILTER_LEN, default 8: number of consecutive identical synchronised samples needed before ps2_clk_in is accepted as a new level.

Ports:
- clk  in  1  system clock, same clock as the keyboard decoder.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte; captured when tx_valid and tx_ready are both high.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  equals !tx_ready.
- tx_done  out  1  one-cycle pulse when the device ACK is received and the bus has returned to idle.
- tx_err  out  1  one-cycle pulse on timeout or NACK.
- ps2_clk_in  in  1  raw level of the PS2_CLK pin.
- ps2_data_in  in  1  raw level of the PS2_DATA pin.
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_data_oe  out  1  1 pulls PS2_DATA low.

Behaviour:
- Reset values:
  - state is IDLE.
  - tx_ready = 1, busy = 0.
  - tx_done = 0, tx_err = 0.
  - ps2_clk_oe = 0, ps2_data_oe = 0 (both lines released immediately, including mid-transfer).
  - All counters and the shift register are 0.
- Input conditioning:
  - Both pins pass through a 2-FF synchroniser.
  - The clock line is then glitch-filtered with FILTER_LEN.
  - fall = one-cycle pulse when the filtered clock goes from 1 to 0.
- Capture: on tx_valid && tx_ready, the block latches the frame {stop=1, parity=~^tx_data, tx_data} with the LSB sent first, and moves to INHIBIT on the next edge. tx_valid while busy is ignored and does not queue.
- State INHIBIT:
  - clk_oe = 1, data_oe = 0.
  - After INHIBIT_CYCLES clocks, go to START.
- State START:
  - data_oe = 1 first, for one cycle with clk_oe still 1. Then clk_oe = 0 (release clock). This is the start bit.
  - Wait for fall. The timeout counter is active.
  - On fall, drive data bit 0 (data_oe = ~bit) and go to DATA with bit_cnt = 1.
- State DATA:
  - On each fall, drive bit[bit_cnt] and increment bit_cnt.
  - After bit 7 is on the line, the next fall drives parity. The fall after that releases data (stop bit, data_oe = 0) and moves to ACK.
- State ACK:
  - On the next fall, sample filtered data. 0 means ACK: go to WAIT_IDLE. 1 means NACK: pulse tx_err and go to IDLE.
- State WAIT_IDLE:
  - Wait until both the filtered clock and the synchronised data are 1.
  - Then pulse tx_done and go to IDLE.
- Timeout:
  - The counter clears on entering START and on every fall. It counts in START, DATA, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines in the same cycle, pulses tx_err and goes to IDLE.
- Pulses: tx_done and tx_err are never high together. Each is high for exactly one clk.
- Timing: data_oe changes only in the cycle after a fall. The latency from fall to the data line update is 1 clk plus FILTER_LEN+2 clks of conditioning delay.
- Counter widths: bit_cnt is 4 bits. The inhibit/timeout counter is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) bits and saturates, so it never wraps.
- Simultaneous events: if a fall and the timeout arrive in the same cycle, the timeout wins.

Decomposition:
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE;
  - the command constants: CMD_SET_LED = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF.
- Sub-module ps2_line_filter: 2-FF sync, FILTER_LEN stability filter and fall pulse. It is reusable by the receive decoder.

Test Plan (simulation parameters: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=2000, FILTER_LEN=4; the device model clocks with a 40-clk period):
- Send 0xED, device ACKs:
  - clk_oe stays high for exactly 100 clks, then data_oe rises, then clk_oe falls.
  - The device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once after the bus is idle. tx_ready returns to 1.
- Send 0x00:
  - Sampled parity = 1.
- Send 0x03:
  - Sampled parity = 1.
- Send 0x07:
  - Sampled parity = 0.
- Device holds data high at the ACK edge:
  - tx_err pulses for exactly 1 clk. tx_done stays 0. Both enables are 0.
- Device never clocks after the start bit:
  - Exactly 2000 clks after clk release, tx_err pulses and data_oe drops to 0.
- Device stalls after bit 4:
  - Timeout abort with the same tx_err pulse. The next tx_valid with 0xF4 completes normally.
- Assert rst at bit 3:
  - Both oe go to 0 asynchronously, before the next clk edge. After release, tx_ready = 1 and no pulse is emitted.
- tx_valid with 0xFF while busy:
  - Ignored. The frame on the wire remains the original byte, and only one tx_done occurs.
- Glitch test: a 2-clk low glitch on ps2_clk_in during DATA.
  - No bit advance. The bit sequence is unchanged.
